mc_mips_ctrl_fsm: RTL and testbench

- Parametrised multicycle MIPS control state machine; successor to the fixed 8-bit, four-beat controller.
- Fetches a 32-bit instruction in 32/DATA_WIDTH memory beats.
- Stalls every memory state on a `mem_ready` handshake, so multi-cycle memories are supported.
- Flags illegal opcodes and emits an instruction-retired pulse. Drives the existing datapath (PC, IR, register file, ALU muxes) unchanged in meaning.

---
 rtl/mc_mips_ctrl_fsm_pkg.sv | 127 ++++++++++++
 rtl/mc_mips_ctrl_fsm_fetch_beat_ctr.sv | 33 +++
 rtl/mc_mips_ctrl_fsm.sv | 105 ++++++++++
 tb/tb_mc_mips_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_mips_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS controller: states, opcodes,
// mux/ALU encodings and the Moore output decode used by the control FSM.
package mc_mips_ctrl_fsm_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      RTYPEEX,
      RTYPEWB,
      BEQEX,
      JEX,
      ADDIEX,
      ADDIWB
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_SB    = 6'h28;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_ONE    = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Purely state-derived controls; mem_ready-gated enables are added in the top.
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       retired;
   } ctrl_t;

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_LB) || (op == OP_SB);
   endfunction

   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_ONE;
         end
         DECODE: begin
            c.alu_src_b = SRCB_IMM_SH;
         end
         MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.retired    = 1'b1;
         end
         MEMWR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         RTYPEEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_REG;
            c.alu_op    = ALU_FUNCT;
         end
         RTYPEWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.retired   = 1'b1;
         end
         BEQEX: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_REG;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PC_ALUOUT;
            c.retired       = 1'b1;
         end
         JEX: begin
            c.pc_write  = 1'b1;
            c.pc_source = PC_JUMP;
            c.retired   = 1'b1;
         end
         ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         ADDIWB: begin
            c.reg_write = 1'b1;
            c.retired   = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_mips_ctrl_fsm_fetch_beat_ctr.sv
// Fetch beat counter: steps through the BEATS memory beats of an instruction
// and provides the one-hot IR lane select for the current beat.
module mc_mips_ctrl_fsm_fetch_beat_ctr #(
   parameter int BEATS = 4,
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             ph1,
   input  logic             reset,
   input  logic             advance,
   output logic             last,
   output logic [BEATS-1:0] beat_onehot
);

   logic [BW-1:0] beat;

   assign last = (beat == BW'(BEATS - 1));

   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         beat <= '0;
      end else if (advance) begin
         beat <= last ? '0 : beat + BW'(1);
      end
   end

   always_comb begin
      beat_onehot = '0;
      for (int i = 0; i < BEATS; i++) begin
         beat_onehot[i] = (beat == BW'(i));
      end
   end

endmodule

// File: rtl/mc_mips_ctrl_fsm.sv
// Multicycle MIPS control FSM with a parametrised fetch width and mem_ready
// stalls on every memory state; outputs are registered Moore decodes.
module mc_mips_ctrl_fsm
   import mc_mips_ctrl_fsm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   localparam int BEATS = 32 / DATA_WIDTH
) (
   input  logic             ph1,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic [BEATS-1:0] ir_write,
   output logic             iord,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             illegal_op,
   output logic             retired
);

   state_t           state;
   state_t           next_state;
   ctrl_t            ctrl_q;
   logic             in_fetch;
   logic             fetch_go;
   logic             beat_last;
   logic [BEATS-1:0] beat_onehot;

   // The zero flag is ANDed with pc_write_cond in the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero;

   assign in_fetch = (state == FETCH);
   assign fetch_go = in_fetch && mem_ready;

   mc_mips_ctrl_fsm_fetch_beat_ctr #(.BEATS(BEATS)) u_fetch_beat_ctr (
      .ph1         (ph1),
      .reset       (reset),
      .advance     (fetch_go),
      .last        (beat_last),
      .beat_onehot (beat_onehot)
   );

   always_comb begin
      next_state = state;
      case (state)
         FETCH:   if (mem_ready && beat_last) next_state = DECODE;
         DECODE: begin
            case (opcode)
               OP_LB, OP_SB: next_state = MEMADR;
               OP_RTYPE:     next_state = RTYPEEX;
               OP_BEQ:       next_state = BEQEX;
               OP_J:         next_state = JEX;
               OP_ADDI:      next_state = ADDIEX;
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:  next_state = (opcode == OP_SB) ? MEMWR : MEMRD;
         MEMRD:   if (mem_ready) next_state = MEMWB;
         MEMWR:   if (mem_ready) next_state = FETCH;
         RTYPEEX: next_state = RTYPEWB;
         ADDIEX:  next_state = ADDIWB;
         default: next_state = FETCH;
      endcase
   end

   // Outputs are decoded from the next state so they are valid from a flop.
   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         state  <= FETCH;
         ctrl_q <= decode_state(FETCH);
      end else begin
         state  <= next_state;
         ctrl_q <= decode_state(next_state);
      end
   end

   assign mem_read      = ctrl_q.mem_read;
   assign mem_write     = ctrl_q.mem_write;
   assign iord          = ctrl_q.iord;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign reg_dst       = ctrl_q.reg_dst;
   assign reg_write     = ctrl_q.reg_write;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_op        = ctrl_q.alu_op;
   assign pc_source     = ctrl_q.pc_source;
   assign pc_write_cond = ctrl_q.pc_write_cond;

   assign ir_write   = beat_onehot & {BEATS{fetch_go && !reset}};
   assign pc_write   = ctrl_q.pc_write || (fetch_go && !reset);
   assign retired    = !reset && (ctrl_q.retired || ((state == MEMWR) && mem_ready));
   assign illegal_op = !reset && (state == DECODE) && !is_legal(opcode);

endmodule

// File: tb/tb_mc_mips_ctrl_fsm.sv
// Self-checking bench for mc_mips_ctrl_fsm: cycle-by-cycle vector table on an
// 8-bit instance plus a reset-during-store sequence on a 32-bit instance.
module tb_mc_mips_ctrl_fsm;

   typedef struct packed {
      logic [3:0] ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       illegal_op;
      logic       retired;
   } out_t;

   typedef struct {
      logic       rdy;
      logic [5:0] op;
      logic       zero;
      out_t       exp;
      string      name;
   } vec_t;

   typedef struct {
      out_t  exp;
      string name;
   } sb_t;

   int checks = 0;
   int failures = 0;
   vec_t vecs[$];
   sb_t  sb[$];

   logic ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   logic       reset8, rdy8, zero8;
   logic [5:0] op8;
   logic       mem_read8, mem_write8, iord8, mem_to_reg8, reg_dst8, reg_write8;
   logic       alu_src_a8, pc_write8, pc_write_cond8, illegal_op8, retired8;
   logic [1:0] alu_src_b8, alu_op8, pc_source8;
   logic [3:0] ir_write8;

   logic       reset32, rdy32, zero32;
   logic [5:0] op32;
   logic       mem_read32, mem_write32, iord32, mem_to_reg32, reg_dst32, reg_write32;
   logic       alu_src_a32, pc_write32, pc_write_cond32, illegal_op32, retired32;
   logic [1:0] alu_src_b32, alu_op32, pc_source32;
   logic [0:0] ir_write32;

   mc_mips_ctrl_fsm #(.DATA_WIDTH(8)) u8 (
      .ph1(ph1), .reset(reset8), .opcode(op8), .zero(zero8), .mem_ready(rdy8),
      .mem_read(mem_read8), .mem_write(mem_write8), .ir_write(ir_write8),
      .iord(iord8), .mem_to_reg(mem_to_reg8), .reg_dst(reg_dst8),
      .reg_write(reg_write8), .alu_src_a(alu_src_a8), .alu_src_b(alu_src_b8),
      .alu_op(alu_op8), .pc_source(pc_source8), .pc_write(pc_write8),
      .pc_write_cond(pc_write_cond8), .illegal_op(illegal_op8), .retired(retired8)
   );

   mc_mips_ctrl_fsm #(.DATA_WIDTH(32)) u32 (
      .ph1(ph1), .reset(reset32), .opcode(op32), .zero(zero32), .mem_ready(rdy32),
      .mem_read(mem_read32), .mem_write(mem_write32), .ir_write(ir_write32),
      .iord(iord32), .mem_to_reg(mem_to_reg32), .reg_dst(reg_dst32),
      .reg_write(reg_write32), .alu_src_a(alu_src_a32), .alu_src_b(alu_src_b32),
      .alu_op(alu_op32), .pc_source(pc_source32), .pc_write(pc_write32),
      .pc_write_cond(pc_write_cond32), .illegal_op(illegal_op32), .retired(retired32)
   );

   function automatic out_t sample8();
      out_t o;
      o.ir_write = ir_write8;       o.mem_read = mem_read8;
      o.mem_write = mem_write8;     o.iord = iord8;
      o.mem_to_reg = mem_to_reg8;   o.reg_dst = reg_dst8;
      o.reg_write = reg_write8;     o.alu_src_a = alu_src_a8;
      o.alu_src_b = alu_src_b8;     o.alu_op = alu_op8;
      o.pc_source = pc_source8;     o.pc_write = pc_write8;
      o.pc_write_cond = pc_write_cond8;
      o.illegal_op = illegal_op8;   o.retired = retired8;
      return o;
   endfunction

   function automatic out_t sample32();
      out_t o;
      o.ir_write = {3'b000, ir_write32}; o.mem_read = mem_read32;
      o.mem_write = mem_write32;     o.iord = iord32;
      o.mem_to_reg = mem_to_reg32;   o.reg_dst = reg_dst32;
      o.reg_write = reg_write32;     o.alu_src_a = alu_src_a32;
      o.alu_src_b = alu_src_b32;     o.alu_op = alu_op32;
      o.pc_source = pc_source32;     o.pc_write = pc_write32;
      o.pc_write_cond = pc_write_cond32;
      o.illegal_op = illegal_op32;   o.retired = retired32;
      return o;
   endfunction

   // Expected outputs per state, written from the control table.
   function automatic out_t o_fetch(input int k, input bit rdy);
      out_t o = '0;
      o.mem_read = 1'b1;
      o.alu_src_b = 2'b01;
      o.ir_write = rdy ? (4'b0001 << k) : 4'b0000;
      o.pc_write = rdy;
      return o;
   endfunction

   function automatic out_t o_decode(input bit ill);
      out_t o = '0;
      o.alu_src_b = 2'b11;
      o.illegal_op = ill;
      return o;
   endfunction

   function automatic out_t o_exec(input logic [1:0] srcb, input logic [1:0] aluop);
      out_t o = '0;
      o.alu_src_a = 1'b1;
      o.alu_src_b = srcb;
      o.alu_op = aluop;
      return o;
   endfunction

   function automatic out_t o_mem(input bit wr, input bit ret);
      out_t o = '0;
      o.mem_read = !wr;
      o.mem_write = wr;
      o.iord = 1'b1;
      o.retired = ret;
      return o;
   endfunction

   function automatic out_t o_wb(input bit from_mem, input bit rd);
      out_t o = '0;
      o.reg_write = 1'b1;
      o.mem_to_reg = from_mem;
      o.reg_dst = rd;
      o.retired = 1'b1;
      return o;
   endfunction

   function automatic out_t o_beqex();
      out_t o = o_exec(2'b00, 2'b01);
      o.pc_write_cond = 1'b1;
      o.pc_source = 2'b01;
      o.retired = 1'b1;
      return o;
   endfunction

   function automatic out_t o_jex();
      out_t o = '0;
      o.pc_write = 1'b1;
      o.pc_source = 2'b10;
      o.retired = 1'b1;
      return o;
   endfunction

   task automatic add(input logic rdy, input logic [5:0] op, input logic z,
                      input out_t e, input string n);
      vec_t v;
      v.rdy = rdy; v.op = op; v.zero = z; v.exp = e; v.name = n;
      vecs.push_back(v);
   endtask

   task automatic add_fetch(input logic [5:0] op, input int stall_beat, input int stall_n);
      for (int k = 0; k < 4; k++) begin
         if (k == stall_beat) begin
            for (int s = 0; s < stall_n; s++)
               add(1'b0, op, 1'b0, o_fetch(k, 1'b0), $sformatf("fetch op%02h beat%0d stall", op, k));
         end
         add(1'b1, op, 1'b0, o_fetch(k, 1'b1), $sformatf("fetch op%02h beat%0d", op, k));
      end
   endtask

   task automatic checkOutput(input out_t act, input out_t exp, input string name);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit wide, input vec_t v);
      sb_t e;
      sb_t got;
      @(negedge ph1);
      if (wide) begin
         rdy32 = v.rdy; op32 = v.op; zero32 = v.zero;
      end else begin
         rdy8 = v.rdy; op8 = v.op; zero8 = v.zero;
      end
      e.exp = v.exp; e.name = v.name;
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      checkOutput(wide ? sample32() : sample8(), got.exp, got.name);
   endtask

   initial begin
      vec_t v;
      reset8 = 1'b1; rdy8 = 1'b1; op8 = 6'h00; zero8 = 1'b0;
      reset32 = 1'b1; rdy32 = 1'b1; op32 = 6'h28; zero32 = 1'b0;

      add_fetch(6'h00, -1, 0);
      add(1, 6'h00, 0, o_decode(0), "rtype decode");
      add(1, 6'h00, 0, o_exec(2'b00, 2'b10), "rtype ex");
      add(1, 6'h00, 0, o_wb(0, 1), "rtype wb");

      add_fetch(6'h20, -1, 0);
      add(1, 6'h20, 0, o_decode(0), "lb decode");
      add(1, 6'h20, 0, o_exec(2'b10, 2'b00), "lb memadr");
      for (int s = 0; s < 3; s++) add(0, 6'h20, 0, o_mem(0, 0), "lb memrd stall");
      add(1, 6'h20, 0, o_mem(0, 0), "lb memrd ready");
      add(1, 6'h20, 0, o_wb(1, 0), "lb memwb");

      add_fetch(6'h08, 2, 2);
      add(1, 6'h08, 0, o_decode(0), "addi decode after stall");
      add(1, 6'h08, 0, o_exec(2'b10, 2'b00), "addi ex");
      add(1, 6'h08, 0, o_wb(0, 0), "addi wb");

      add_fetch(6'h04, -1, 0);
      add(1, 6'h04, 1, o_decode(0), "beq z1 decode");
      add(1, 6'h04, 1, o_beqex(), "beq z1 ex");
      add_fetch(6'h04, -1, 0);
      add(1, 6'h04, 0, o_decode(0), "beq z0 decode");
      add(1, 6'h04, 0, o_beqex(), "beq z0 ex");

      add_fetch(6'h02, -1, 0);
      add(1, 6'h02, 0, o_decode(0), "j decode");
      add(1, 6'h02, 0, o_jex(), "j ex");

      add_fetch(6'h3f, -1, 0);
      add(1, 6'h3f, 0, o_decode(1), "illegal 3f decode");
      add_fetch(6'h23, -1, 0);
      add(1, 6'h23, 0, o_decode(1), "illegal 23 decode");

      add_fetch(6'h28, -1, 0);
      add(1, 6'h28, 0, o_decode(0), "sb decode");
      add(1, 6'h28, 0, o_exec(2'b10, 2'b00), "sb memadr");
      add(0, 6'h28, 0, o_mem(1, 0), "sb memwr stall");
      add(1, 6'h28, 0, o_mem(1, 1), "sb memwr ready");

      add_fetch(6'h00, -1, 0);
      add(0, 6'h00, 0, o_decode(0), "rtype decode rdy0");
      add(0, 6'h00, 0, o_exec(2'b00, 2'b10), "rtype ex rdy0");
      add(0, 6'h00, 0, o_wb(0, 1), "rtype wb rdy0");
      add(1, 6'h00, 0, o_fetch(0, 1), "final fetch beat0");

      #12;
      checkOutput(sample8(), o_fetch(0, 0), "reset outputs w8");
      checkOutput(sample32(), o_fetch(0, 0), "reset outputs w32");
      rdy8 = 1'b0;
      reset8 = 1'b0;

      foreach (vecs[i]) applyStimulus(1'b0, vecs[i]);

      @(negedge ph1);
      rdy32 = 1'b0;
      #1 reset32 = 1'b0;
      v.op = 6'h28; v.zero = 1'b0;
      v.rdy = 1; v.exp = o_fetch(0, 1);          v.name = "w32 fetch";        applyStimulus(1'b1, v);
      v.rdy = 1; v.exp = o_decode(0);            v.name = "w32 sb decode";    applyStimulus(1'b1, v);
      v.rdy = 1; v.exp = o_exec(2'b10, 2'b00);   v.name = "w32 sb memadr";    applyStimulus(1'b1, v);
      v.rdy = 0; v.exp = o_mem(1, 0);            v.name = "w32 memwr stall";  applyStimulus(1'b1, v);
      #1 reset32 = 1'b1;
      #1 checkOutput(sample32(), o_fetch(0, 0), "w32 reset mid memwr");
      rdy32 = 1'b1;
      #1 checkOutput(sample32(), o_fetch(0, 0), "w32 reset rdy forced");
      @(negedge ph1);
      reset32 = 1'b0;
      #1 checkOutput(sample32(), o_fetch(0, 1), "w32 post-reset fetch");
      @(negedge ph1);
      #1 checkOutput(sample32(), o_decode(0), "w32 post-reset decode");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
